display_scan_driver: RTL and testbench

Time-multiplexed 4-digit hex display scanner that sits directly upstream of the hex-to-7-segment decoder. It holds a 16-bit display value and cycles through its four nibbles at a programmable rate. For each nibble it presents the bits on `A`..`D` to the decoder and drives the matching active-low digit anode. Value updates are double-buffered and take effect only at frame boundaries, so a digit never shows a mixed value.

---
 rtl/display_scan_driver.sv | 161 ++++++++++++++++
 tb/tb_display_scan_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
// display_scan_driver
// -------------------------------------------------------------------------
// Time-multiplexed scanner for a 4-digit hex display. It sits upstream of a
// hex-to-7-segment decoder. A prescaler sets how long each digit stays lit.
// A 2-bit digit index walks the four nibbles of the active display value.
// New values are captured into a pending buffer and promoted to the active
// buffer only at frame boundaries (digit index wrapping 3->0), so a frame
// never mixes old and new digits.
//
// Ports
//   clk        : system clock, rising-edge active
//   rst        : synchronous active-high reset
//   value_in   : 16-bit value; digit 0 = [3:0] (rightmost), digit 3 = [15:12]
//   load       : one-cycle strobe, captures value_in into the pending buffer
//   blank_lz   : leading-zero blanking enable (combinational effect)
//   A,B,C,D    : current nibble to the decoder, A = MSB, D = LSB
//   anode_n    : active-low one-hot digit enable, bit i = digit i
//   frame_done : one-cycle pulse in the first cycle of each new frame
// -------------------------------------------------------------------------
module display_scan_driver #(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic [3:0]  anode_n,
    output logic        frame_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic [15:0]      pending_q, pending_d;
    logic             pv_q, pv_d;
    logic [15:0]      active_q, active_d;
    logic             frame_done_q, frame_done_d;

    logic             tc_s;
    logic             wrap_s;
    logic [3:0]       nibble_s;
    logic             blank_s;

    // Next-state logic for prescaler, digit index and the double buffer.
    always_comb begin
        tc_s         = (cnt_q == CNT_TC);
        wrap_s       = tc_s && (dig_q == 2'd3);

        cnt_d        = cnt_q;
        dig_d        = dig_q;
        pending_d    = pending_q;
        pv_d         = pv_q;
        active_d     = active_q;
        frame_done_d = wrap_s;

        // With CLK_DIV = 1 the terminal count is always hit, so the counter
        // stays at zero and the digit advances every cycle.
        if (tc_s) begin
            cnt_d = {CNT_W{1'b0}};
            dig_d = dig_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            dig_d = dig_q;
        end

        if (load) begin
            pending_d = value_in;
        end else begin
            pending_d = pending_q;
        end

        // A load coinciding with the wrap bypasses the pending buffer so the
        // newest value is shown from the very first digit of the new frame.
        if (wrap_s) begin
            pv_d = 1'b0;
            if (load) begin
                active_d = value_in;
            end else if (pv_q) begin
                active_d = pending_q;
            end else begin
                active_d = active_q;
            end
        end else if (load) begin
            pv_d     = 1'b1;
            active_d = active_q;
        end else begin
            pv_d     = pv_q;
            active_d = active_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= {CNT_W{1'b0}};
            dig_q        <= 2'd0;
            pending_q    <= 16'h0000;
            pv_q         <= 1'b0;
            active_q     <= 16'h0000;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            pending_q    <= pending_d;
            pv_q         <= pv_d;
            active_q     <= active_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Nibble select and leading-zero detection for the current digit.
    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        nibble_s = 4'h0;
        blank_s  = 1'b0;
        case (dig_q)
            2'd0: begin
                nibble_s = active_q[3:0];
                blank_s  = 1'b0;
            end
            2'd1: begin
                nibble_s = active_q[7:4];
                blank_s  = blank_lz && (active_q[15:4] == 12'h000);
            end
            2'd2: begin
                nibble_s = active_q[11:8];
                blank_s  = blank_lz && (active_q[15:8] == 8'h00);
            end
            2'd3: begin
                nibble_s = active_q[15:12];
                blank_s  = blank_lz && (active_q[15:12] == 4'h0);
            end
            default: begin
                nibble_s = 4'h0;
                blank_s  = 1'b0;
            end
        endcase
    end

    // Output drive: the nibble is presented even while its anode is blanked.
    always_comb begin
        A = nibble_s[3];
        B = nibble_s[2];
        C = nibble_s[1];
        D = nibble_s[0];
        if (blank_s) begin
            anode_n = 4'b1111;
        end else begin
            anode_n = ~(4'b0001 << dig_q);
        end
        frame_done = frame_done_q;
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver. Two instances (CLK_DIV = 4 and
// CLK_DIV = 1) share one stimulus stream. The driver advances a behavioural
// model one clock at a time and queues the expected post-edge view. A
// separate monitor pops and compares just after each rising edge.
module tb_display_scan_driver;

    localparam int N4 = 4;
    localparam int N1 = 1;

    typedef struct {
        int          k;      // clock edges since the last reset edge
        logic [15:0] shown;  // value currently on the display
        logic [15:0] pend;   // newest value waiting for a frame boundary
        bit          pflag;
        bit          fd;
    } model_t;

    typedef struct {
        logic [15:0] shown;
        int          dig;
        bit          fd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic        blank_lz;

    logic        a4, b4, c4, d4, fd4;
    logic [3:0]  an4;
    logic        a1, b1, c1, d1, fd1;
    logic [3:0]  an1;

    int checks;
    int errors;

    model_t m4;
    model_t m1;
    exp_t   q4[$];
    exp_t   q1[$];

    display_scan_driver #(.CLK_DIV(N4)) dut4 (
        .clk(clk), .rst(rst), .value_in(value_in), .load(load), .blank_lz(blank_lz),
        .A(a4), .B(b4), .C(c4), .D(d4), .anode_n(an4), .frame_done(fd4)
    );

    display_scan_driver #(.CLK_DIV(N1)) dut1 (
        .clk(clk), .rst(rst), .value_in(value_in), .load(load), .blank_lz(blank_lz),
        .A(a1), .B(b1), .C(c1), .D(d1), .anode_n(an1), .frame_done(fd1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame-level model: a frame is 4*n edges long, the digit shown is
    // (k / n) mod 4, and the newest load up to a frame boundary is shown
    // from that boundary on.
    function automatic model_t step(model_t m, int n, bit r, bit ld, logic [15:0] v);
        model_t x;
        x = m;
        if (r) begin
            x.k = 0; x.shown = 16'h0; x.pend = 16'h0; x.pflag = 1'b0; x.fd = 1'b0;
        end else begin
            x.k = m.k + 1;
            if (ld) begin
                x.pend  = v;
                x.pflag = 1'b1;
            end
            x.fd = ((x.k % (4 * n)) == 0);
            if (x.fd && x.pflag) begin
                x.shown = x.pend;
                x.pflag = 1'b0;
            end
        end
        return x;
    endfunction

    function automatic exp_t view(model_t m, int n);
        exp_t e;
        e.shown = m.shown;
        e.dig   = (m.k / n) % 4;
        e.fd    = m.fd;
        return e;
    endfunction

    task automatic compare(string tag, exp_t e, logic [3:0] abcd, logic [3:0] an, logic fd);
        logic [15:0] sh;
        logic [3:0]  exp_nib;
        logic [3:0]  exp_an;
        sh      = e.shown >> (4 * e.dig);
        exp_nib = sh[3:0];
        if (blank_lz && (e.dig > 0) && (sh == 16'h0))
            exp_an = 4'b1111;
        else
            exp_an = 4'b1111 ^ (4'b0001 << e.dig);
        checks = checks + 3;
        if (abcd !== exp_nib) begin
            errors = errors + 1;
            $display("FAIL %s abcd t=%0t got %b want %b", tag, $time, abcd, exp_nib);
        end
        if (an !== exp_an) begin
            errors = errors + 1;
            $display("FAIL %s anode_n t=%0t got %b want %b", tag, $time, an, exp_an);
        end
        if (fd !== e.fd) begin
            errors = errors + 1;
            $display("FAIL %s frame_done t=%0t got %b want %b", tag, $time, fd, e.fd);
        end
    endtask

    // Monitor: one output sample per rising edge, taken just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q4.size() > 0) begin
                e = q4.pop_front();
                compare("div4", e, {a4, b4, c4, d4}, an4, fd4);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                compare("div1", e, {a1, b1, c1, d1}, an1, fd1);
            end
        end
    end

    // One clock of stimulus, applied on the falling edge.
    task automatic cyc(bit r, bit ld, logic [15:0] v, bit bl);
        @(negedge clk);
        rst      = r;
        load     = ld;
        value_in = v;
        blank_lz = bl;
        m4 = step(m4, N4, r, ld, v);
        m1 = step(m1, N1, r, ld, v);
        q4.push_back(view(m4, N4));
        q1.push_back(view(m1, N1));
    endtask

    task automatic idle(int n, bit bl);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, bl);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        load     = 1'b0;
        value_in = 16'h0;
        blank_lz = 1'b0;
        m4 = '{0, 16'h0, 16'h0, 1'b0, 1'b0};
        m1 = '{0, 16'h0, 16'h0, 1'b0, 1'b0};

        // Reset held, including a load that must be ignored.
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        cyc(1'b1, 1'b1, 16'hDEAD, 1'b0);
        // Two idle frames of the CLK_DIV=4 instance.
        idle(34, 1'b0);

        // Mid-frame load, then another frame so it is shown.
        while ((m4.k / N4) % 4 != 1) cyc(1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 1'b1, 16'h1A3F, 1'b0);
        idle(36, 1'b0);

        // Two loads within one frame: only the second is ever shown.
        cyc(1'b0, 1'b1, 16'h1111, 1'b0);
        idle(3, 1'b0);
        cyc(1'b0, 1'b1, 16'h2222, 1'b0);
        idle(36, 1'b0);

        // Load exactly on the wrap edge of the CLK_DIV=4 instance.
        while (((m4.k + 1) % (4 * N4)) != 0) cyc(1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b0, 1'b1, 16'hBEEF, 1'b0);
        idle(20, 1'b0);

        // Leading-zero blanking with 0x0050, then with zero.
        cyc(1'b0, 1'b1, 16'h0050, 1'b1);
        idle(36, 1'b1);
        cyc(1'b0, 1'b1, 16'h0000, 1'b1);
        idle(36, 1'b1);

        // Reset with a load pending mid-frame.
        cyc(1'b0, 1'b1, 16'h7777, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        idle(20, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
                16'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Drain the scoreboards with a bounded wait.
        for (int i = 0; i < 5 && (q4.size() > 0 || q1.size() > 0); i++) @(posedge clk);
        #2;
        checks = checks + 1;
        if (q4.size() != 0 || q1.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending got %0d/%0d want 0/0", q4.size(), q1.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
